// File: rtl/freq_store_pkg.sv
// Shared types and constants for the frequency-indexed ring sample store.
package freq_store_pkg;

  localparam logic MODE_RING    = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // One extra bit lets a one-shot channel count up to exactly DEPTH.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int seg_width(input int n_seg);
    return $clog2(n_seg);
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one enabled read port with registered output.
module sdp_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // A same-address read in a write cycle returns the old word.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/freq_ring_store.sv
// Per-channel sample store: {slot, channel} data RAM, per-channel slot counters,
// ring/one-shot modes, clear sweep, segment notifications and drop accounting.
module freq_ring_store
  import freq_store_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int N_FREQ     = 128,
  parameter int DEPTH      = 32,
  parameter int N_SEG      = 2,
  parameter int DROP_W     = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [DATA_WIDTH-1:0]                  data_in,
  input  logic [$clog2(N_FREQ)-1:0]              index,
  input  logic                                   valid,
  input  logic                                   mode,
  input  logic                                   clear,
  output logic                                   busy,
  input  logic                                   rd_en,
  input  logic [$clog2(DEPTH)+$clog2(N_FREQ)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]                  rd_data,
  output logic                                   rd_valid,
  output logic                                   seg_done,
  output logic [$clog2(N_SEG)-1:0]               seg_id,
  output logic [$clog2(N_FREQ)-1:0]              seg_chan,
  output logic                                   all_full,
  output logic [DROP_W-1:0]                      drop_cnt
);

  localparam int IDX_W   = $clog2(N_FREQ);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = cnt_width(DEPTH);
  localparam int SEG_W   = seg_width(N_SEG);
  localparam int SEG_LEN = DEPTH / N_SEG;
  localparam int TALLY_W = IDX_W + 1;

  state_e                  state, state_next;
  logic [IDX_W-1:0]        sweep_addr;
  logic                    mode_q;
  logic                    s1_valid, s1_fwd;
  logic [IDX_W-1:0]        s1_index;
  logic [DATA_WIDTH-1:0]   s1_data;
  logic [CNT_W-1:0]        fwd_cnt, cnt_rdata, cnt, cnt_next;
  logic [PTR_W-1:0]        ptr;
  logic [TALLY_W-1:0]      full_tally;
  logic                    s0_accept, s1_live, can_write, s1_write, s1_drop;
  logic                    seg_hit, full_hit, drop_inc;
  logic                    ctr_we;
  logic [IDX_W-1:0]        ctr_waddr;
  logic [CNT_W-1:0]        ctr_wdata;

  assign busy     = (state == ST_CLEAR);
  assign all_full = (full_tally == TALLY_W'(N_FREQ));

  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned, which would infer a latch.
    state_next = state;
    case (state)
      ST_CLEAR: if (!clear && sweep_addr == IDX_W'(N_FREQ - 1)) state_next = ST_RUN;
      ST_RUN:   if (clear) state_next = ST_CLEAR;
      default:  state_next = ST_CLEAR;
    endcase
  end

  // The RAM still holds the pre-write count when S1 updates the same channel, so forward it.
  always_comb begin
    s0_accept = valid && (state == ST_RUN) && !clear;
    s1_live   = s1_valid && !clear;
    cnt       = s1_fwd ? fwd_cnt : cnt_rdata;
    ptr       = cnt[PTR_W-1:0];
    can_write = (mode_q == MODE_RING) || !cnt[PTR_W];
    if (mode_q == MODE_RING) cnt_next = {1'b0, ptr + PTR_W'(1)};
    else if (can_write)      cnt_next = cnt + CNT_W'(1);
    else                     cnt_next = cnt;
    s1_write  = s1_live && can_write;
    s1_drop   = s1_live && !can_write;
    seg_hit   = s1_write && ((ptr & PTR_W'(SEG_LEN - 1)) == PTR_W'(SEG_LEN - 1));
    full_hit  = s1_write && (mode_q == MODE_ONESHOT) && (cnt_next == CNT_W'(DEPTH));
    drop_inc  = s1_drop || (valid && (busy || clear));
    ctr_we    = busy || s1_live;
    ctr_waddr = busy ? sweep_addr : s1_index;
    ctr_wdata = busy ? '0 : cnt_next;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state      <= ST_CLEAR;
      sweep_addr <= '0;
      mode_q     <= mode;
      s1_valid   <= 1'b0;
      s1_fwd     <= 1'b0;
      s1_index   <= '0;
      s1_data    <= '0;
      fwd_cnt    <= '0;
      seg_done   <= 1'b0;
      seg_id     <= '0;
      seg_chan   <= '0;
      drop_cnt   <= '0;
      full_tally <= '0;
      rd_valid   <= 1'b0;
    end else begin
      state      <= state_next;
      sweep_addr <= (clear || state == ST_RUN) ? '0 : sweep_addr + IDX_W'(1);
      if (clear) mode_q <= mode;
      s1_valid   <= s0_accept;
      s1_index   <= index;
      s1_data    <= data_in;
      s1_fwd     <= s0_accept && s1_live && (s1_index == index);
      fwd_cnt    <= cnt_next;
      seg_done   <= seg_hit;
      if (seg_hit) begin
        seg_id   <= ptr[PTR_W-1 -: SEG_W];
        seg_chan <= s1_index;
      end
      if (clear)                          drop_cnt <= DROP_W'(valid);
      else if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
      if (clear)         full_tally <= '0;
      else if (full_hit) full_tally <= full_tally + TALLY_W'(1);
      rd_valid   <= rd_en;
    end
  end

  sdp_ram #(.WIDTH(CNT_W), .DEPTH(N_FREQ)) u_cnt_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ctr_we),
    .waddr (ctr_waddr),
    .wdata (ctr_wdata),
    .re    (s0_accept),
    .raddr (index),
    .rdata (cnt_rdata)
  );

  sdp_ram #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH * N_FREQ)) u_data_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (s1_write),
    .waddr ({ptr, s1_index}),
    .wdata (s1_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule

// File: doc/freq_ring_store.md
Name: freq_ring_store

Overview:
Successor to the per-frequency sample store. It captures tone samples tagged with a frequency index into per-channel slots in one shared data RAM, addressed as {slot, channel}. A per-channel write-counter RAM tracks the next slot for each channel.
- Adds over the previous generation: selectable ring or one-shot mode, an automatic and on-demand counter-clear sweep, and read-modify-write forwarding for back-to-back same-index samples.
- Also adds: generalised segment-complete notification, a full-channel tally, and drop accounting.
- Sits between the channel demux/selector and the host readout (AXI/DMA) side.

Parameters:
DATA_WIDTH, 64, sample width
N_FREQ, 128, channel count; power of 2, >=2
DEPTH, 32, slots per channel; power of 2, >=2
N_SEG, 2, segments per channel ring for notification; power of 2, 2..DEPTH
DROP_W, 16, drop counter width

Ports:
clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
data_in  in  DATA_WIDTH  sample
index  in  log2(N_FREQ)  channel of sample
valid  in  1  sample qualifier; no backpressure
mode  in  1  0 = ring, 1 = one-shot; latched on CLEAR entry
clear  in  1  pulse: restart clear sweep
busy  out  1  high while in CLEAR
rd_en  in  1  read request
rd_addr  in  log2(DEPTH)+log2(N_FREQ)  {slot, channel}
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data qualifier
seg_done  out  1  one-cycle pulse: a channel finished a segment
seg_id  out  log2(N_SEG)  segment just completed
seg_chan  out  log2(N_FREQ)  channel of seg_done
all_full  out  1  one-shot: every channel holds DEPTH samples
drop_cnt  out  DROP_W  saturating count of dropped samples

Behaviour:
- Reset values: busy=1, rd_valid=0, rd_data=0, seg_done=0, seg_id=0, seg_chan=0, all_full=0, drop_cnt=0. FSM enters CLEAR with sweep address 0. Counter RAM contents are not reset by rst; the sweep zeroes them.
- FSM states: CLEAR, RUN.
  - CLEAR: writes 0 to counter address a, a = 0..N_FREQ-1, one per cycle. Moves to RUN after address N_FREQ-1, so busy is high for exactly N_FREQ cycles.
  - RUN -> CLEAR on clear. clear asserted during CLEAR restarts the sweep at 0.
  - On CLEAR entry: mode is latched; drop_cnt and the full-channel tally are zeroed; all_full drops to 0.
- Write pipeline, two stages:
  - S0, cycle t: counter RAM read at index, registered with 1-cycle latency.
  - S1, cycle t+1: counter value cnt is available. Data RAM write at {ptr, index}; counter write-back.
  - Sample data is readable by rd_en issued at t+2.
- Forwarding: if the S1 write index equals the index arriving in S0, the next S1 uses the forwarded written count, not the RAM output. Back-to-back same-index samples therefore land in consecutive slots. Gaps of any length must also work.
- Counter width is log2(DEPTH)+1; ptr = cnt[log2(DEPTH)-1:0].
  - Ring mode: always write; cnt_next = (cnt+1) mod DEPTH, wrapping and overwriting the oldest sample.
  - One-shot mode: write only if cnt < DEPTH, then cnt_next = cnt+1. When cnt_next == DEPTH, the full tally increments. all_full=1 when the tally == N_FREQ.
  - One-shot sample to a channel with cnt == DEPTH: no write; drop_cnt increments.
- Dropped samples:
  - valid during CLEAR, including the cycle clear is asserted, increments drop_cnt.
  - Samples in S0/S1 when clear is asserted are discarded: no data or counter write, no seg_done, no drop count.
  - drop_cnt saturates at all-ones.
- seg_done: registered at the S1 write cycle, so it rises at t+2.
  - Asserted when (ptr+1) mod (DEPTH/N_SEG) == 0.
  - seg_id = ptr[MSB -: log2(N_SEG)]; seg_chan = index.
  - Also fires in one-shot mode for each written segment.
- Read port: rd_en at cycle r gives rd_data and rd_valid=1 at r+1. rd_data holds its value while rd_en is low. Reads are allowed in every state.
- Read-during-write to the same address returns the old data.

Decomposition:
- Shared package freq_store_pkg holds:
  - MODE_RING=0 and MODE_ONESHOT=1.
  - FSM state encodings ST_CLEAR and ST_RUN.
  - Helper constants for counter width and segment width.
- One natural sub-module: sdp_ram.
  - Inferred simple dual-port RAM: one write port, one read port with enable, 1-cycle registered read, parameterised width/depth.
  - Instantiated twice: data RAM and counter RAM.

Test Plan:
1. Release rst with valid=1 on ch0 for the first 10 cycles -> busy=1 for exactly 128 cycles, drop_cnt=10, then busy=0; next sample to ch0 lands at slot 0.
2. Ring mode: 5 back-to-back samples 0xA0..0xA4 on ch3 -> reads at {0..4,3} return 0xA0..0xA4; rd_valid one cycle after each rd_en.
3. Ring mode, N_SEG=2: 33 samples 0..32 on ch7 -> seg_done with seg_id=0 after the 16th sample, seg_id=1 after the 32nd; slot 0 reads 32 and slot 1 reads 1.
4. One-shot mode: 40 samples on ch1 -> slots 0..31 hold the first 32, drop_cnt=8. Fill all 128 channels to 32 -> all_full=1 the cycle after the final write.
5. Alternate ch0/ch1 every cycle, interleaved with same-index pairs and 1-cycle gaps -> every channel's slots are sequential with no skips or duplicates.
6. Assert clear with samples in S0/S1 -> those samples are not written; after 128 busy cycles, the next sample on that channel goes to slot 0, and the mode latched at clear is in effect.
